udi_spect_dens_acc: RTL and testbench
=====================================

# udi_spect_dens_acc

Parametrised, integrating successor to the single-sample spectral-density UDI datapath: computes instantaneous I/Q power I²+Q² per sample, accumulates it over a programmable power-of-two window, and presents either the raw sum, the window average or the per-sample power to the UDI result bus, together with a threshold detection flag. It sits in the core's UDI slot behind the instruction decoder and is driven by the UDI control decode (`udi_ctl_*`).

## Interface
- `DATA_W`, 16: signed I and Q sample width; products are 2·DATA_W bits.
- `LOG2_NMAX`, 8: maximum integration window is 2^LOG2_NMAX samples.
- `ACC_W`, 2·DATA_W+LOG2_NMAX: accumulator width (derived, not overridden).
---
- `gclk`  in  1  sole clock, all state on the rising edge.
- `greset`  in  1  asynchronous, active-high reset.
- `gscanenable`  in  1  scan enable; forces config-register clock enables on.
- `in_rs`  in  2·DATA_W  I in upper half, Q in lower half, signed two's complement; also the config write data.
- `in_valid`  in  1  sample strobe.
- `udi_ctl_thr_wr`  in  1  load `threshold` from `in_rs[31:0]`.
- `udi_ctl_len_wr`  in  1  load `len_log2` from `in_rs[3:0]`.
- `udi_ctl_clr`  in  1  flush integration.
- `udi_ctl_sum_mode`  in  2  00 NONE, 01 SUM, 10 AVG, 11 BYPASS.
- `udi_ctl_res_sel`  in  1  1: `out_rd = {31'd0, det}`; 0: result.
- `out_rd`  out  32  result mux.
- `out_valid`  out  1  one-cycle pulse when result updates.
- `out_det`  out  1  detection flag.
- `out_busy`  out  1  integration or pipeline non-empty.

## Operation
- Stage 1: `sq_i = I*I`, `sq_q = Q*Q` registered with valid bit.
- Stage 2: `pwr = sq_i + sq_q` (2·DATA_W bits unsigned, cannot overflow) registered with valid bit.
- Window N = 2^len_log2; `len_log2 > LOG2_NMAX` clamps to LOG2_NMAX. BYPASS forces N = 1.
- FSM: IDLE → ACCUM on first valid `pwr` (acc ← pwr, cnt ← 1); ACCUM adds each valid `pwr`, cnt++; when cnt reaches N (after the add) → DUMP. From IDLE with N = 1, go directly to DUMP.
- DUMP (one cycle): result ← f(acc); `out_valid` = 1; if a valid `pwr` arrives in the same cycle, acc ← pwr, cnt ← 1, next state ACCUM (or DUMP again if N = 1); else IDLE.
- f(acc): NONE → 0; SUM → acc[31:0], saturated to 32'hFFFF_FFFF if acc ≥ 2^32; AVG → acc >> len_log2 (always fits); BYPASS → acc[31:0]. Mode is sampled in the DUMP cycle.
- Detection is updated in the DUMP cycle: `det = (f(acc) > threshold)`, unsigned compare.
- `udi_ctl_len_wr` or `udi_ctl_clr`: clear both pipeline valids, acc, cnt; FSM → IDLE. Result, `det`, `threshold` and `len_log2` are held. A sample presented in the same cycle is discarded. A config write wins over a coincident DUMP: no `out_valid` pulse.
- `udi_ctl_thr_wr` does not disturb integration. The new threshold applies from the next DUMP.
- `out_busy = (state != IDLE) | v1 | v2`.

## Timing
- Sample in cycle t → `pwr` valid in t+2 → DUMP/`out_valid` in t+3 for the last sample of a window. `out_rd` and `out_det` are valid from t+4 and held until the next DUMP.
- Full throughput: one sample per cycle, back-to-back windows, no bubbles.
- Reset values: `out_rd` 0, `out_valid` 0, `out_det` 0, `out_busy` 0, threshold 0, `len_log2` 0, FSM IDLE.
- Reset mid-window discards everything asynchronously.

## Configuration
- `UDI_SD_HYST_EN` defined: `det` gains hysteresis. It sets when result > threshold and clears only when result < threshold − (threshold >> 3); otherwise it holds.
- Not defined: `det` is the plain compare above and is recomputed at every DUMP.

## Structure
- Package `udi_sd_pkg`: sum-mode localparams (NONE, SUM, AVG, BYPASS), FSM state enum, `ACC_W` derivation function.
- One sub-module, `udi_sd_power`: the two-stage signed-square-and-add pipeline with valid propagation. The FSM, accumulator, result and detection logic stay in the top.

## Test plan
- Reset/BYPASS: after reset, all outputs are 0. Send I = 3, Q = −4 in BYPASS → 3 cycles later `out_valid` pulses and `out_rd` = 25.
- SUM window: `len_log2` = 2; send (1,1), (2,0), (0,3), (−1,−1) back-to-back → a single `out_valid`, `out_rd` = 2+4+9+2 = 17.
- AVG plus saturation: `len_log2` = 8 with I = Q = −32768 for 256 samples. AVG mode → `out_rd` = 0x8000_0000. SUM mode → 0xFFFF_FFFF.
- Detection: threshold = 100; BYPASS samples (6,8), then (10,1) → `det` = 0, then 1. With `UDI_SD_HYST_EN`, a following (9,2) (power 85 < 88) clears `det`, and (9,3) (power 90) keeps it set.
- Mid-window abort: `len_log2` = 3; after 5 samples assert `udi_ctl_clr` → no `out_valid`, `out_busy` falls the next cycle, and a fresh 8-sample window is then accumulated correctly.
- Simultaneous events: `len_wr` coinciding with DUMP → no pulse and the new length takes effect. `in_valid` coinciding with `clr` → the sample is dropped.

Source files
------------

// File: rtl/udi_sd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udi_sd_pkg
// Description : Shared definitions for the spectral-density integrator.
//               Provides the result-mode codes, the FSM state type and the
//               accumulator width derivation.
// Revision    : 1.0 - initial release
// ============================================================================
package udi_sd_pkg;

    // Result-mode codes carried on udi_ctl_sum_mode
    localparam logic [1:0] c_MODE_NONE   = 2'b00;
    localparam logic [1:0] c_MODE_SUM    = 2'b01;
    localparam logic [1:0] c_MODE_AVG    = 2'b10;
    localparam logic [1:0] c_MODE_BYPASS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DUMP  = 2'd2
    } sd_state_e;

    // Sum of 2^log2_nmax values of 2*data_w bits needs log2_nmax extra bits
    function automatic int calc_acc_w(input int data_w, input int log2_nmax);
        return 2 * data_w + log2_nmax;
    endfunction

endpackage
`default_nettype wire

// File: rtl/udi_sd_power.sv
`default_nettype none
// ============================================================================
// Module      : udi_sd_power
// Description : Two-stage instantaneous power pipeline, pwr = I*I + Q*Q.
//               Stage 1 registers both squares, stage 2 registers their sum.
// Ports       : clk, rst (async, active high)
//               i_flush     - drop everything in flight (and the input)
//               i_valid     - sample strobe, i_i / i_q signed samples
//               o_v1        - stage-1 occupancy
//               o_pwr_valid - stage-2 valid, o_pwr unsigned power
// Revision    : 1.0 - initial release
// ============================================================================
module udi_sd_power #(
    parameter int DATA_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_flush,
    input  logic                      i_valid,
    input  logic signed [DATA_W-1:0]  i_i,
    input  logic signed [DATA_W-1:0]  i_q,
    output logic                      o_v1,
    output logic                      o_pwr_valid,
    output logic [2*DATA_W-1:0]       o_pwr
);

    localparam int c_PW = 2 * DATA_W;

    logic signed [c_PW-1:0] w_prod_i;
    logic signed [c_PW-1:0] w_prod_q;
    logic [c_PW-1:0]        sq_i_d, sq_i_q;
    logic [c_PW-1:0]        sq_q_d, sq_q_q;
    logic [c_PW-1:0]        pwr_d,  pwr_q;
    logic                   v1_d,   v1_q;
    logic                   v2_d,   v2_q;

    // Operands are sign-extended to the full product width; a square is
    // never negative, so the product can be reinterpreted as unsigned.
    assign w_prod_i = i_i * i_i;
    assign w_prod_q = i_q * i_q;

    always_comb begin
        sq_i_d = sq_i_q;
        sq_q_d = sq_q_q;
        pwr_d  = pwr_q;
        v1_d   = i_valid & ~i_flush;
        v2_d   = v1_q & ~i_flush;
        if (i_valid) begin
            sq_i_d = $unsigned(w_prod_i);
            sq_q_d = $unsigned(w_prod_q);
        end
        // Max is 2 * 2^(2*DATA_W-2), so the sum fits in 2*DATA_W bits
        if (v1_q) begin
            pwr_d = sq_i_q + sq_q_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_i_q <= '0;
            sq_q_q <= '0;
            pwr_q  <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
        end else begin
            sq_i_q <= sq_i_d;
            sq_q_q <= sq_q_d;
            pwr_q  <= pwr_d;
            v1_q   <= v1_d;
            v2_q   <= v2_d;
        end
    end

    assign o_v1        = v1_q;
    assign o_pwr_valid = v2_q;
    assign o_pwr       = pwr_q;

endmodule
`default_nettype wire

// File: rtl/udi_spect_dens_acc.sv
`default_nettype none
// ============================================================================
// Module      : udi_spect_dens_acc
// Description : Integrating spectral-density UDI datapath. Squares I/Q,
//               accumulates power over a 2^len_log2 window and returns the
//               sum, average or per-sample power plus a threshold flag.
// Ports       : gclk, greset (async, active high), gscanenable
//               in_rs[2*DATA_W-1:0]  I (upper) / Q (lower), config data
//               in_valid             sample strobe
//               udi_ctl_thr_wr / len_wr / clr / sum_mode / res_sel
//               out_rd, out_valid, out_det, out_busy
// Options     : define UDI_SD_HYST_EN for a detection flag with hysteresis
// Revision    : 1.0 - initial release
// ============================================================================
module udi_spect_dens_acc
    import udi_sd_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int LOG2_NMAX = 8
) (
    input  logic                  gclk,
    input  logic                  greset,
    input  logic                  gscanenable,
    input  logic [2*DATA_W-1:0]   in_rs,
    input  logic                  in_valid,
    input  logic                  udi_ctl_thr_wr,
    input  logic                  udi_ctl_len_wr,
    input  logic                  udi_ctl_clr,
    input  logic [1:0]            udi_ctl_sum_mode,
    input  logic                  udi_ctl_res_sel,
    output logic [31:0]           out_rd,
    output logic                  out_valid,
    output logic                  out_det,
    output logic                  out_busy
);

    localparam int         ACC_W     = calc_acc_w(DATA_W, LOG2_NMAX);
    localparam int         c_PW      = 2 * DATA_W;
    localparam int         c_CNT_W   = LOG2_NMAX + 1;
    localparam logic [3:0] c_NMAX_L2 = 4'(LOG2_NMAX);

    logic [31:0]        w_cfg;
    logic               w_flush;
    logic               w_v1;
    logic               w_pwr_valid;
    logic [c_PW-1:0]    w_pwr;
    logic [3:0]         w_len_eff;
    logic [c_CNT_W-1:0] w_win;
    logic [31:0]        w_f;
    logic               w_det_new;
    logic               w_dump;
    logic [ACC_W-1:0]   w_acc_sum;
    logic [c_CNT_W-1:0] w_cnt_inc;

    sd_state_e          state_d,    state_q;
    logic [ACC_W-1:0]   acc_d,      acc_q;
    logic [c_CNT_W-1:0] cnt_d,      cnt_q;
    logic [31:0]        result_d,   result_q;
    logic               det_d,      det_q;
    logic [31:0]        thr_d,      thr_q;
    logic [3:0]         len_log2_d, len_log2_q;

    // Config word is always the low 32 bits of in_rs
    generate
        if (c_PW >= 32) begin : g_cfg_trunc
            assign w_cfg = in_rs[31:0];
        end else begin : g_cfg_ext
            assign w_cfg = {{(32 - c_PW){1'b0}}, in_rs};
        end
    endgenerate

    assign w_flush = udi_ctl_len_wr | udi_ctl_clr;

    udi_sd_power #(
        .DATA_W (DATA_W)
    ) u_power (
        .clk         (gclk),
        .rst         (greset),
        .i_flush     (w_flush),
        .i_valid     (in_valid),
        .i_i         ($signed(in_rs[c_PW-1:DATA_W])),
        .i_q         ($signed(in_rs[DATA_W-1:0])),
        .o_v1        (w_v1),
        .o_pwr_valid (w_pwr_valid),
        .o_pwr       (w_pwr)
    );

    // Scan forces the config enables so the registers shift with the chain
    assign thr_d      = (udi_ctl_thr_wr | gscanenable) ? w_cfg      : thr_q;
    assign len_log2_d = (udi_ctl_len_wr | gscanenable) ? w_cfg[3:0] : len_log2_q;

    assign w_len_eff = (len_log2_q > c_NMAX_L2) ? c_NMAX_L2 : len_log2_q;
    assign w_win     = (udi_ctl_sum_mode == c_MODE_BYPASS) ? c_CNT_W'(1)
                                                           : (c_CNT_W'(1) << w_len_eff);

    // Result function of the current accumulator
    always_comb begin
        w_f = '0;
        case (udi_ctl_sum_mode)
            c_MODE_SUM:    w_f = (|acc_q[ACC_W-1:32]) ? 32'hFFFF_FFFF : acc_q[31:0];
            c_MODE_AVG:    w_f = 32'(acc_q >> w_len_eff);
            c_MODE_BYPASS: w_f = acc_q[31:0];
            default:       w_f = '0;
        endcase
    end

`ifdef UDI_SD_HYST_EN
    // Set above threshold, clear only below threshold minus 1/8, else hold
    always_comb begin
        w_det_new = det_q;
        if (w_f > thr_q) begin
            w_det_new = 1'b1;
        end else if (w_f < (thr_q - (thr_q >> 3))) begin
            w_det_new = 1'b0;
        end
    end
`else
    assign w_det_new = (w_f > thr_q);
`endif

    assign w_acc_sum = acc_q + ACC_W'(w_pwr);
    assign w_cnt_inc = cnt_q + c_CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        det_d    = det_q;
        w_dump   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_pwr_valid) begin
                    acc_d   = ACC_W'(w_pwr);
                    cnt_d   = c_CNT_W'(1);
                    state_d = (w_win == c_CNT_W'(1)) ? ST_DUMP : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_pwr_valid) begin
                    acc_d = w_acc_sum;
                    cnt_d = w_cnt_inc;
                    // >= keeps the window closing even if the mode is
                    // switched to BYPASS mid-window
                    if (w_cnt_inc >= w_win) begin
                        state_d = ST_DUMP;
                    end
                end
            end
            ST_DUMP: begin
                w_dump   = 1'b1;
                result_d = w_f;
                det_d    = w_det_new;
                if (w_pwr_valid) begin
                    acc_d   = ACC_W'(w_pwr);
                    cnt_d   = c_CNT_W'(1);
                    state_d = (w_win == c_CNT_W'(1)) ? ST_DUMP : ST_ACCUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Flush overrides everything, including a coincident dump
        if (w_flush) begin
            state_d  = ST_IDLE;
            acc_d    = '0;
            cnt_d    = '0;
            result_d = result_q;
            det_d    = det_q;
            w_dump   = 1'b0;
        end
    end

    always_ff @(posedge gclk or posedge greset) begin
        if (greset) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            det_q      <= 1'b0;
            thr_q      <= '0;
            len_log2_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            det_q      <= det_d;
            thr_q      <= thr_d;
            len_log2_q <= len_log2_d;
        end
    end

    assign out_rd    = udi_ctl_res_sel ? {31'd0, det_q} : result_q;
    assign out_valid = w_dump;
    assign out_det   = det_q;
    assign out_busy  = (state_q != ST_IDLE) | w_v1 | w_pwr_valid;

endmodule
`default_nettype wire

// File: tb/tb_udi_spect_dens_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_udi_spect_dens_acc
// Description : Scoreboard bench for udi_spect_dens_acc. Stimulus pushes the
//               expected result/flag per window; a monitor pops and compares
//               one cycle after every out_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udi_spect_dens_acc;

    localparam logic [1:0] M_NONE   = 2'b00;
    localparam logic [1:0] M_SUM    = 2'b01;
    localparam logic [1:0] M_AVG    = 2'b10;
    localparam logic [1:0] M_BYPASS = 2'b11;
`ifdef UDI_SD_HYST_EN
    localparam logic HYST = 1'b1;
`else
    localparam logic HYST = 1'b0;
`endif

    logic        gclk = 1'b0;
    logic        greset;
    logic        gscanenable;
    logic [31:0] in_rs;
    logic        in_valid;
    logic        udi_ctl_thr_wr;
    logic        udi_ctl_len_wr;
    logic        udi_ctl_clr;
    logic [1:0]  udi_ctl_sum_mode;
    logic        udi_ctl_res_sel;
    logic [31:0] out_rd;
    logic        out_valid;
    logic        out_det;
    logic        out_busy;

    udi_spect_dens_acc #(
        .DATA_W    (16),
        .LOG2_NMAX (8)
    ) dut (
        .gclk             (gclk),
        .greset           (greset),
        .gscanenable      (gscanenable),
        .in_rs            (in_rs),
        .in_valid         (in_valid),
        .udi_ctl_thr_wr   (udi_ctl_thr_wr),
        .udi_ctl_len_wr   (udi_ctl_len_wr),
        .udi_ctl_clr      (udi_ctl_clr),
        .udi_ctl_sum_mode (udi_ctl_sum_mode),
        .udi_ctl_res_sel  (udi_ctl_res_sel),
        .out_rd           (out_rd),
        .out_valid        (out_valid),
        .out_det          (out_det),
        .out_busy         (out_busy)
    );

    always #5 gclk = ~gclk;

    typedef struct packed {
        logic [31:0] rd;
        logic        det;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_en  = 1'b0;
    logic pend    = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge gclk);
        #1;
    endtask

    task automatic push(input logic [31:0] rd, input logic det);
        exp_t e;
        e.rd  = rd;
        e.det = det;
        exp_q.push_back(e);
    endtask

    task automatic send(input int i, input int q);
        in_rs    = {16'(i), 16'(q)};
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic set_len(input logic [31:0] v);
        in_rs          = v;
        udi_ctl_len_wr = 1'b1;
        cyc();
        udi_ctl_len_wr = 1'b0;
    endtask

    task automatic set_thr(input logic [31:0] v);
        in_rs          = v;
        udi_ctl_thr_wr = 1'b1;
        cyc();
        udi_ctl_thr_wr = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 2000; k++) begin
            if (!out_busy) break;
            cyc();
        end
        chk("drain_timeout", {31'd0, out_busy}, 32'd0);
        cyc();
        cyc();
    endtask

    // Monitor: result and flag are checked the cycle after the pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge gclk);
            if (mon_en) begin
                if (pend) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_valid: got pulse with out_rd=0x%08h, expected none", out_rd);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_rd",  out_rd, e.rd);
                        chk("sb_det", {31'd0, out_det}, {31'd0, e.det});
                    end
                end
                pend = out_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        greset           = 1'b1;
        gscanenable      = 1'b0;
        in_rs            = '0;
        in_valid         = 1'b0;
        udi_ctl_thr_wr   = 1'b0;
        udi_ctl_len_wr   = 1'b0;
        udi_ctl_clr      = 1'b0;
        udi_ctl_sum_mode = M_BYPASS;
        udi_ctl_res_sel  = 1'b0;
        repeat (3) @(posedge gclk);
        #1;
        chk("rst_rd",    out_rd, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_det",   {31'd0, out_det},   32'd0);
        chk("rst_busy",  {31'd0, out_busy},  32'd0);
        greset = 1'b0;
        cyc();
        mon_en = 1'b1;

        // BYPASS single sample, with latency check
        send(3, -4);
        push(32'd25, 1'b1);
        @(negedge gclk); chk("lat_t1", {31'd0, out_valid}, 32'd0);
        @(negedge gclk); chk("lat_t2", {31'd0, out_valid}, 32'd0);
        @(negedge gclk); chk("lat_t3", {31'd0, out_valid}, 32'd1);
        cyc();
        wait_idle();

        // SUM over 4 samples
        udi_ctl_sum_mode = M_SUM;
        set_len(32'd2);
        send(1, 1); send(2, 0); send(0, 3); send(-1, -1);
        push(32'd17, 1'b1);
        wait_idle();

        // AVG and SUM saturation over 256 max-power samples
        set_len(32'd8);
        udi_ctl_sum_mode = M_AVG;
        for (int n = 0; n < 256; n++) send(-32768, -32768);
        push(32'h8000_0000, 1'b1);
        wait_idle();
        udi_ctl_sum_mode = M_SUM;
        for (int n = 0; n < 256; n++) send(-32768, -32768);
        push(32'hFFFF_FFFF, 1'b1);
        wait_idle();

        // Detection around threshold 100 (hysteresis low mark is 88)
        set_thr(32'd100);
        set_len(32'd0);
        udi_ctl_sum_mode = M_BYPASS;
        send(0, 0);   push(32'd0,   1'b0);
        send(6, 8);   push(32'd100, 1'b0);
        send(10, 1);  push(32'd101, 1'b1);
        send(9, 3);   push(32'd90,  HYST);
        send(9, 2);   push(32'd85,  1'b0);
        send(10, 1);  push(32'd101, 1'b1);
        wait_idle();
        udi_ctl_res_sel = 1'b1;
        #1;
        chk("res_sel_det", out_rd, 32'd1);
        udi_ctl_res_sel = 1'b0;
        cyc();

        // Mid-window clear with a coincident (dropped) sample
        udi_ctl_sum_mode = M_SUM;
        set_len(32'd3);
        for (int n = 0; n < 5; n++) send(1, 0);
        in_rs       = {16'd100, 16'd0};
        in_valid    = 1'b1;
        udi_ctl_clr = 1'b1;
        cyc();
        in_valid    = 1'b0;
        udi_ctl_clr = 1'b0;
        @(negedge gclk);
        chk("clr_busy", {31'd0, out_busy}, 32'd0);
        cyc();
        for (int n = 0; n < 8; n++) send(2, 1);
        push(32'd40, 1'b0);
        wait_idle();

        // Length write coinciding with the dump cycle
        set_len(32'd1);
        send(1, 1);
        send(1, 1);
        cyc();
        cyc();
        in_rs          = 32'd0;
        udi_ctl_len_wr = 1'b1;
        @(negedge gclk);
        chk("lenwr_dump_busy",  {31'd0, out_busy},  32'd1);
        chk("lenwr_dump_valid", {31'd0, out_valid}, 32'd0);
        cyc();
        udi_ctl_len_wr = 1'b0;
        cyc();
        chk("lenwr_hold_rd", out_rd, 32'd40);
        send(3, 4);
        push(32'd25, 1'b0);
        wait_idle();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
